// File: rtl/board_io_pkg.sv
// Shared types and sizing helpers for the board I/O front end.
package board_io_pkg;

  // Largest brightness code for a PWM counter of the given width.
  function automatic int unsigned pwm_max(input int unsigned bits);
    return (32'd1 << bits) - 32'd1;
  endfunction

  // Width of a debounce counter that must reach DEBOUNCE_CYCLES-1.
  function automatic int unsigned dbc_cnt_w(input int unsigned cycles);
    return $clog2(cycles + 32'd1);
  endfunction

  localparam int unsigned MAX_BTN = 16;
  localparam int unsigned MAX_SW  = 32;

  // Board-top status bundle sized for the largest supported configuration.
  typedef struct packed {
    logic [MAX_BTN-1:0] btn;
    logic [MAX_BTN-1:0] rise;
    logic [MAX_SW-1:0]  sw;
    logic               chg;
  } board_io_status_t;

endpackage

// File: rtl/io_debounce.sv
// Two-flop synchroniser plus per-bit debounce; reports registered level and change pulse.
module io_debounce
  import board_io_pkg::*;
#(
  parameter int unsigned WIDTH           = 1,
  parameter int unsigned DEBOUNCE_CYCLES = 1
) (
  input  logic             clk_i,
  input  logic             srst_i,
  input  logic [WIDTH-1:0] i_pin,
  output logic [WIDTH-1:0] o_level,
  output logic [WIDTH-1:0] o_chg
);

  localparam int unsigned  CW   = dbc_cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] r_s1;
  logic [WIDTH-1:0] r_s2;
  logic [WIDTH-1:0] r_st;
  logic [WIDTH-1:0] r_chg;
  logic [CW-1:0]    r_cnt [WIDTH];
  logic [WIDTH-1:0] w_load;

  // A bit is accepted once the synced level has differed for the full window.
  always_comb begin
    w_load = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      w_load[i] = (r_s2[i] != r_st[i]) && (r_cnt[i] == LAST);
    end
  end

  // Synchroniser, stability counters, accepted level and change pulse.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      r_s1  <= '0;
      r_s2  <= '0;
      r_st  <= '0;
      r_chg <= '0;
      for (int i = 0; i < int'(WIDTH); i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_s1  <= i_pin;
      r_s2  <= r_s1;
      r_st  <= r_st ^ w_load;
      r_chg <= w_load;
      for (int i = 0; i < int'(WIDTH); i++) begin
        if ((r_s2[i] == r_st[i]) || w_load[i]) begin
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CW'(1);
        end
      end
    end
  end

  assign o_level = r_st;
  assign o_chg   = r_chg;

endmodule

// File: rtl/board_io_ctrl.sv
// Board I/O front end: debounced buttons/switches, button IRQs, LED brightness PWM.
module board_io_ctrl
  import board_io_pkg::*;
#(
  parameter int unsigned NUM_BTN         = 1,
  parameter int unsigned NUM_SW          = 16,
  parameter int unsigned NUM_LED         = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 100000,
  parameter int unsigned PWM_BITS        = 4
) (
  input  logic                clk_i,
  input  logic                srst_i,
  input  logic [NUM_BTN-1:0]  btn_i,
  input  logic [NUM_SW-1:0]   sw_i,
  output logic [NUM_BTN-1:0]  btn_o,
  output logic [NUM_BTN-1:0]  btn_rise_o,
  output logic [NUM_SW-1:0]   sw_o,
  output logic                sw_chg_o,
  input  logic [NUM_BTN-1:0]  irq_en_i,
  input  logic [NUM_BTN-1:0]  irq_ack_i,
  output logic [NUM_BTN-1:0]  irq_pend_o,
  output logic                irq_o,
  input  logic [NUM_LED-1:0]  led_i,
  input  logic [PWM_BITS-1:0] led_bright_i,
  output logic [NUM_LED-1:0]  led_o
);

  localparam int unsigned PWM_MAX = pwm_max(PWM_BITS);

  logic [NUM_BTN-1:0]  w_btn_lvl;
  logic [NUM_BTN-1:0]  w_btn_chg;
  logic [NUM_SW-1:0]   w_sw_lvl;
  logic [NUM_SW-1:0]   w_sw_chg;
  logic                w_on;
  logic [NUM_BTN-1:0]  r_pend;
  logic [PWM_BITS-1:0] r_pcnt;
  logic [NUM_LED-1:0]  r_led;

  io_debounce #(
    .WIDTH           (NUM_BTN),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_btn_deb (
    .clk_i   (clk_i),
    .srst_i  (srst_i),
    .i_pin   (btn_i),
    .o_level (w_btn_lvl),
    .o_chg   (w_btn_chg)
  );

  io_debounce #(
    .WIDTH           (NUM_SW),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_sw_deb (
    .clk_i   (clk_i),
    .srst_i  (srst_i),
    .i_pin   (sw_i),
    .o_level (w_sw_lvl),
    .o_chg   (w_sw_chg)
  );

  // LED enable for this PWM slot; full-scale code forces always-on.
  always_comb begin
    w_on = (led_bright_i == PWM_BITS'(PWM_MAX)) || (r_pcnt < led_bright_i);
  end

  // Pending IRQs (new rise wins over ack), PWM counter and LED output register.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      r_pend <= '0;
      r_pcnt <= '0;
      r_led  <= '0;
    end else begin
      r_pend <= (r_pend & ~irq_ack_i) | (btn_rise_o & irq_en_i);
      r_pcnt <= r_pcnt + PWM_BITS'(1);
      r_led  <= led_i & {NUM_LED{w_on}};
    end
  end

  // Edge pulses are gates of flops only, so they line up with the new level.
  assign btn_o      = w_btn_lvl;
  assign btn_rise_o = w_btn_chg & w_btn_lvl;
  assign sw_o       = w_sw_lvl;
  assign sw_chg_o   = |w_sw_chg;
  assign irq_pend_o = r_pend;
  assign irq_o      = |r_pend;
  assign led_o      = r_led;

endmodule

// File: tb/tb_board_io_ctrl.sv
// Self-checking bench for board_io_ctrl against a cycle-level behavioural model.
module tb_board_io_ctrl;

  localparam int NB = 4;
  localparam int NS = 16;
  localparam int NL = 16;
  localparam int D  = 4;
  localparam int PB = 4;

  logic          clk = 1'b0;
  logic          srst;
  logic [NB-1:0] btn, btn_o, btn_rise_o, irq_en, irq_ack, irq_pend_o;
  logic [NS-1:0] sw, sw_o;
  logic          sw_chg_o, irq_o;
  logic [NL-1:0] led, led_o;
  logic [PB-1:0] bright;

  int n_cmp = 0;
  int n_fail = 0;

  // Model state: synced pin history, accepted level, run length of disagreement.
  logic [NB-1:0] mb_s1, mb_s2, mb_st, mb_chg;
  int            mb_run [NB];
  logic [NS-1:0] ms_s1, ms_s2, ms_st, ms_chg;
  int            ms_run [NS];
  logic [NB-1:0] m_pend;
  int            m_pcnt;
  logic [NL-1:0] m_led;

  always #5 clk = ~clk;

  board_io_ctrl #(
    .NUM_BTN(NB), .NUM_SW(NS), .NUM_LED(NL), .DEBOUNCE_CYCLES(D), .PWM_BITS(PB)
  ) dut (
    .clk_i(clk), .srst_i(srst), .btn_i(btn), .sw_i(sw),
    .btn_o(btn_o), .btn_rise_o(btn_rise_o), .sw_o(sw_o), .sw_chg_o(sw_chg_o),
    .irq_en_i(irq_en), .irq_ack_i(irq_ack), .irq_pend_o(irq_pend_o), .irq_o(irq_o),
    .led_i(led), .led_bright_i(bright), .led_o(led_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock using the inputs the DUT sampled.
  task automatic model_edge();
    logic [NB-1:0] old_rise;
    old_rise = mb_chg & mb_st;
    if (srst) begin
      mb_s1 = '0; mb_s2 = '0; mb_st = '0; mb_chg = '0;
      ms_s1 = '0; ms_s2 = '0; ms_st = '0; ms_chg = '0;
      for (int i = 0; i < NB; i++) mb_run[i] = 0;
      for (int i = 0; i < NS; i++) ms_run[i] = 0;
      m_pend = '0; m_pcnt = 0; m_led = '0;
    end else begin
      mb_chg = '0;
      for (int i = 0; i < NB; i++) begin
        if (mb_s2[i] != mb_st[i]) begin
          mb_run[i]++;
          if (mb_run[i] == D) begin mb_st[i] = ~mb_st[i]; mb_run[i] = 0; mb_chg[i] = 1'b1; end
        end else mb_run[i] = 0;
      end
      ms_chg = '0;
      for (int i = 0; i < NS; i++) begin
        if (ms_s2[i] != ms_st[i]) begin
          ms_run[i]++;
          if (ms_run[i] == D) begin ms_st[i] = ~ms_st[i]; ms_run[i] = 0; ms_chg[i] = 1'b1; end
        end else ms_run[i] = 0;
      end
      mb_s2 = mb_s1; mb_s1 = btn;
      ms_s2 = ms_s1; ms_s1 = sw;
      m_pend = (m_pend & ~irq_ack) | (old_rise & irq_en);
      m_led  = ((int'(bright) == 15) || (m_pcnt < int'(bright))) ? led : '0;
      m_pcnt = (m_pcnt + 1) % 16;
    end
  endtask

  // One clock: update the model at the edge, compare every output 1 time unit later.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("btn_o",      32'(btn_o),      32'(mb_st));
    check("btn_rise_o", 32'(btn_rise_o), 32'(mb_chg & mb_st));
    check("sw_o",       32'(sw_o),       32'(ms_st));
    check("sw_chg_o",   32'(sw_chg_o),   32'(|ms_chg));
    check("irq_pend_o", 32'(irq_pend_o), 32'(m_pend));
    check("irq_o",      32'(irq_o),      32'(|m_pend));
    check("led_o",      32'(led_o),      32'(m_led));
  endtask

  initial begin
    int k, cnt;
    srst = 1'b1; btn = '0; sw = '0; irq_en = '0; irq_ack = '0; led = '0; bright = '0;
    repeat (3) step();
    srst = 1'b0;

    // Button press held: level after 2+D cycles, one rise, then pending IRQ.
    repeat (9) step();
    btn[0] = 1'b1; irq_en = '1;
    cnt = 0;
    for (k = 1; k <= 20; k++) begin step(); if (btn_rise_o[0]) cnt++; if (btn_o[0]) break; end
    check("btn_latency", 32'(k), 32'(D + 2));
    step(); if (btn_rise_o[0]) cnt++;
    check("btn_rise_count", 32'(cnt), 32'd1);
    check("irq_after_press", 32'(irq_o), 32'd1);

    // Short glitch never gets accepted.
    btn[1] = 1'b1; repeat (3) step(); btn[1] = 1'b0;
    repeat (10) step();
    check("glitch_level", 32'(btn_o[1]), 32'd0);
    check("glitch_pend",  32'(irq_pend_o[1]), 32'd0);

    // Ack coincident with a new rise keeps the bit; ack alone clears it.
    btn[0] = 1'b0; repeat (10) step();
    btn[0] = 1'b1;
    for (k = 0; k < 20; k++) begin step(); if (btn_rise_o[0]) break; end
    check("rise_seen", 32'(btn_rise_o[0]), 32'd1);
    irq_ack[0] = 1'b1; step();
    check("ack_vs_set", 32'(irq_pend_o[0]), 32'd1);
    step();
    check("ack_clear", 32'(irq_pend_o[0]), 32'd0);
    irq_ack = '0;

    // Masked rise never becomes pending, even after enabling.
    irq_en[2] = 1'b0; btn[2] = 1'b1; repeat (10) step();
    check("masked_pend", 32'(irq_pend_o[2]), 32'd0);
    irq_en[2] = 1'b1; repeat (3) step();
    check("late_enable", 32'(irq_pend_o[2]), 32'd0);

    // PWM duty over one full period for three brightness codes.
    led = 16'hA5A5;
    bright = 4'd4;  cnt = 0; for (int i = 0; i < 16; i++) begin step(); if (led_o == 16'hA5A5) cnt++; end
    check("pwm_b4",  32'(cnt), 32'd4);
    bright = 4'd15; cnt = 0; for (int i = 0; i < 16; i++) begin step(); if (led_o == 16'hA5A5) cnt++; end
    check("pwm_b15", 32'(cnt), 32'd16);
    bright = 4'd0;  cnt = 0; for (int i = 0; i < 16; i++) begin step(); if (led_o != 16'h0000) cnt++; end
    check("pwm_b0",  32'(cnt), 32'd0);

    // Multi-bit switch change: one pulse, full latency.
    sw = 16'h00FF; cnt = 0;
    for (k = 1; k <= 20; k++) begin step(); if (sw_chg_o) cnt++; if (sw_o == 16'h00FF) break; end
    check("sw_latency", 32'(k), 32'(D + 2));
    repeat (6) begin step(); if (sw_chg_o) cnt++; end
    check("sw_chg_count", 32'(cnt), 32'd1);

    // Reset mid-debounce clears everything and restarts the latency.
    sw = 16'h0F0F; repeat (3) step();
    srst = 1'b1; step();
    check("rst_sw",  32'(sw_o), 32'd0);
    check("rst_btn", 32'(btn_o), 32'd0);
    srst = 1'b0;
    for (k = 1; k <= 20; k++) begin step(); if (sw_o == 16'h0F0F) break; end
    check("sw_latency_after_rst", 32'(k), 32'(D + 2));

    // Randomised traffic with occasional resets.
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < NB; i++) if ($urandom_range(0, 7) == 0) btn[i] = ~btn[i];
      if ($urandom_range(0, 15) == 0) sw = sw ^ NS'($urandom);
      if ($urandom_range(0, 7) == 0) irq_en = NB'($urandom);
      irq_ack = ($urandom_range(0, 3) == 0) ? NB'($urandom) : '0;
      if ($urandom_range(0, 31) == 0) led = NL'($urandom);
      if ($urandom_range(0, 23) == 0) bright = PB'($urandom);
      srst = ($urandom_range(0, 199) == 0);
      step();
    end
    srst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/board_io_ctrl.md
Name: board_io_ctrl

Overview:
Parametrised board-level I/O front end between raw FPGA pins and the SoC core's GPIO/IRQ inputs. It supersedes hand-wired button/switch/LED hookup in per-board tops. Features:
- 2-flop synchronisation and debouncing of N buttons and M switches.
- Edge-triggered, maskable, write-1-clear button interrupts.
- Global-brightness PWM on the LED outputs.
One instance per board top, clocked from the PLL output clock.

Parameters:
NUM_BTN, 1, number of push-button channels (1..16)
NUM_SW, 16, number of slide-switch channels (1..32)
NUM_LED, 16, number of LED channels (1..32)
DEBOUNCE_CYCLES, 100000, consecutive stable cycles required to accept a new level (>=1)
PWM_BITS, 4, width of PWM counter and brightness input (1..8)

Ports:
clk_i  in  1  system clock (PLL output)
srst_i  in  1  synchronous reset, active-high
btn_i  in  NUM_BTN  raw asynchronous button pins
sw_i  in  NUM_SW  raw asynchronous switch pins
btn_o  out  NUM_BTN  debounced button levels
btn_rise_o  out  NUM_BTN  one-cycle pulse on debounced 0->1
sw_o  out  NUM_SW  debounced switch levels
sw_chg_o  out  1  one-cycle pulse when any debounced switch changes
irq_en_i  in  NUM_BTN  per-button interrupt enable
irq_ack_i  in  NUM_BTN  write-1-clear of pending bits (level, sampled every cycle)
irq_pend_o  out  NUM_BTN  pending interrupt bits
irq_o  out  1  OR of irq_pend_o
led_i  in  NUM_LED  LED request from core
led_bright_i  in  PWM_BITS  global brightness
led_o  out  NUM_LED  PWM-modulated LED pins

Behaviour:
- Reset (synchronous, srst_i=1 at rising edge):
  - All sync flops, debounce counters, stable states, pulses, pending bits, PWM counter and led_o go to 0.
  - A button held during reset is seen as a 0->1 event after reset.
- Synchroniser: two flops per channel, s1<=pin, s2<=s1.
- Debounce, per channel; stable state st and counter cnt of width $clog2(DEBOUNCE_CYCLES+1):
  - If s2==st: cnt<=0.
  - Else if cnt==DEBOUNCE_CYCLES-1: st<=s2, cnt<=0.
  - Else: cnt<=cnt+1.
  - st therefore changes exactly DEBOUNCE_CYCLES cycles after s2 first differs, provided s2 holds throughout.
  - Any glitch back to st restarts the count.
  - Pin-to-btn_o latency = 2 + DEBOUNCE_CYCLES cycles.
- Edge pulses (registered):
  - btn_rise_o[i] is high exactly in the first cycle btn_o[i]==1.
  - Falling edges produce no pulse.
  - sw_chg_o is high in the first cycle after any sw_o bit changes; simultaneous changes give one pulse.
- IRQ pending, per bit:
  - Next value = (pend & ~ack) | (rise & en).
  - Set and ack in the same cycle: set wins, bit stays 1.
  - irq_en_i low masks new events only; it does not clear existing pending bits.
  - irq_o = |irq_pend_o, combinational from the register, so same cycle as pending.
- PWM:
  - pcnt is a PWM_BITS free-running counter; it wraps from 2^PWM_BITS-1 to 0.
  - on = (led_bright_i == all-ones) | (pcnt < led_bright_i).
  - led_o <= led_i & {NUM_LED{on}}, registered, 1-cycle latency from led_i.
  - Bright 0: always off. Bright k (0<k<max): on for k of every 2^PWM_BITS cycles. Bright max: always on.
  - Changing led_bright_i mid-period takes effect on the next cycle; no glitch filtering.
- Reset mid-operation: a debounce in progress is discarded. After reset the full 2 + DEBOUNCE_CYCLES latency applies again.
- No combinational path from any raw pin to any output.

Decomposition:
- Package board_io_pkg:
  - PWM_MAX localparam function of PWM_BITS.
  - Debounce counter width function.
  - Packed struct of {btn, rise, sw, chg} for wiring board tops.
- Sub-module io_debounce:
  - Parameters WIDTH and DEBOUNCE_CYCLES; contains the synchroniser, per-bit counter and st.
  - Instantiated twice, once for buttons and once for switches.
- IRQ and PWM logic sit in board_io_ctrl.

Test Plan:
- DEBOUNCE_CYCLES=4; btn_i[0] 0->1 at cycle 10, held -> btn_o[0]=1 from cycle 16; btn_rise_o[0] high only in cycle 16; irq_en_i=1, so irq_pend_o[0]=1 and irq_o=1 from cycle 17.
- DEBOUNCE_CYCLES=4; btn_i[0] pulses high 3 cycles then low -> btn_o stays 0, no rise, no irq.
- Pending bit set; irq_ack_i[0]=1 coincident with a new rise on bit 0 -> irq_pend_o[0] stays 1. Ack alone next cycle -> cleared.
- irq_en_i=0 and a rise occurs -> irq_pend_o stays 0. Enabling afterwards raises no interrupt.
- PWM_BITS=4, led_i=16'hA5A5:
  - bright=4 -> led_o=16'hA5A5 for 4 of each 16 cycles, else 0.
  - bright=15 -> constant 16'hA5A5.
  - bright=0 -> constant 0.
- sw_i changes from 16'h0000 to 16'h00FF in one cycle -> sw_o=16'h00FF after 2+DEBOUNCE_CYCLES cycles; single sw_chg_o pulse. srst_i asserted mid-debounce -> all outputs 0 next cycle; full latency restarts.
